alu_scheduler: RTL and testbench

//  Shares the single 32-bit ALU (add/sub/and/or/xor/sll/srl, negedge-registered, gated by enable)

---
 rtl/alu_pkg.sv | 26 ++
 rtl/rr_arbiter.sv | 33 +++
 rtl/alu_scheduler.sv | 141 ++++++++++++++
 tb/tb_alu_scheduler.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its scheduler: op codes, FSM encoding, default widths.
package alu_pkg;

   localparam int unsigned DATA_W_DEF  = 32;
   localparam int unsigned OP_W_DEF    = 4;
   localparam int unsigned NUM_OPS_DEF = 7;

   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [3:0] ALU_SUB = 4'd1;
   localparam logic [3:0] ALU_AND = 4'd2;
   localparam logic [3:0] ALU_OR  = 4'd3;
   localparam logic [3:0] ALU_XOR = 4'd4;
   localparam logic [3:0] ALU_SLL = 4'd5;
   localparam logic [3:0] ALU_SRL = 4'd6;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_RESP  = 2'd2
   } sched_state_t;

   function automatic logic op_is_legal(input logic [31:0] op, input int unsigned num_ops);
      return (op < num_ops);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first asserted request at or above ptr (wrapping) wins.
module rr_arbiter #(
   parameter int unsigned N     = 2,
   parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] grant_idx,
   output logic             grant_valid
);

   int j_s;

   // Rotating priority search starting at ptr.
   always_comb begin
      grant       = '0;
      grant_idx   = '0;
      grant_valid = 1'b0;
      j_s         = 0;
      for (int k = 0; k < int'(N); k++) begin
         j_s = (int'(ptr) + k) % int'(N);
         if (!grant_valid && req[j_s]) begin
            grant[j_s]  = 1'b1;
            grant_idx   = IDX_W'(j_s);
            grant_valid = 1'b1;
         end else begin
            grant_valid = grant_valid;
         end
      end
   end

endmodule

// File: rtl/alu_scheduler.sv
// Shares one ALU among NUM_REQ requesters: round-robin grant, one op at a time,
// operands latched at grant, result captured after a single enable cycle.
module alu_scheduler
   import alu_pkg::*;
#(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned DATA_W  = DATA_W_DEF,
   parameter int unsigned OP_W    = OP_W_DEF,
   parameter int unsigned NUM_OPS = NUM_OPS_DEF
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ*DATA_W-1:0] req_opA,
   input  logic [NUM_REQ*DATA_W-1:0] req_opB,
   input  logic [NUM_REQ*OP_W-1:0]   req_op,
   output logic [NUM_REQ-1:0]        resp_valid,
   input  logic [NUM_REQ-1:0]        resp_ready,
   output logic [DATA_W-1:0]         resp_data,
   output logic                      resp_err,
   output logic                      busy,
   output logic                      alu_enable,
   output logic [DATA_W-1:0]         alu_opA,
   output logic [DATA_W-1:0]         alu_opB,
   output logic [OP_W-1:0]           alu_op,
   input  logic [DATA_W-1:0]         alu_result
);

   localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   sched_state_t     state_q, state_d;
   logic [IDX_W-1:0] rr_ptr_q;
   logic [IDX_W-1:0] owner_q;
   logic [DATA_W-1:0] alu_opa_q, alu_opb_q;
   logic [OP_W-1:0]  alu_op_q;
   logic [DATA_W-1:0] resp_data_q;
   logic             resp_err_q;

   logic [NUM_REQ-1:0] grant_s;
   logic [IDX_W-1:0]   grant_idx_s;
   logic               grant_valid_s;
   logic [OP_W-1:0]    grant_op_s;
   logic               grant_legal_s;
   logic               take_s;
   logic [IDX_W-1:0]   ptr_next_s;

   rr_arbiter #(
      .N     (NUM_REQ),
      .IDX_W (IDX_W)
   ) u_arb (
      .req         (req_valid),
      .ptr         (rr_ptr_q),
      .grant       (grant_s),
      .grant_idx   (grant_idx_s),
      .grant_valid (grant_valid_s)
   );

   assign grant_op_s    = req_op[int'(grant_idx_s)*OP_W +: OP_W];
   assign grant_legal_s = op_is_legal(32'(grant_op_s), NUM_OPS);
   assign take_s        = (state_q == S_IDLE) && grant_valid_s;
   assign ptr_next_s    = (grant_idx_s == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx_s + IDX_W'(1);

   // State register, operand/owner capture and response register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         rr_ptr_q    <= '0;
         owner_q     <= '0;
         alu_opa_q   <= '0;
         alu_opb_q   <= '0;
         alu_op_q    <= '0;
         resp_data_q <= '0;
         resp_err_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         if (take_s) begin
            alu_opa_q <= req_opA[int'(grant_idx_s)*DATA_W +: DATA_W];
            alu_opb_q <= req_opB[int'(grant_idx_s)*DATA_W +: DATA_W];
            alu_op_q  <= grant_op_s;
            owner_q   <= grant_idx_s;
            rr_ptr_q  <= ptr_next_s;
            // Illegal op bypasses the ALU and answers with an error immediately.
            if (!grant_legal_s) begin
               resp_data_q <= '0;
               resp_err_q  <= 1'b1;
            end
         end else if (state_q == S_ISSUE) begin
            resp_data_q <= alu_result;
            resp_err_q  <= 1'b0;
         end
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (grant_valid_s) begin
               state_d = grant_legal_s ? S_ISSUE : S_RESP;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ISSUE: state_d = S_RESP;
         S_RESP: begin
            if (resp_ready[owner_q]) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_RESP;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output decode.
   always_comb begin
      req_ready  = '0;
      resp_valid = '0;
      alu_enable = 1'b0;
      busy       = 1'b1;
      case (state_q)
         S_IDLE: begin
            req_ready = grant_s;
            busy      = 1'b0;
         end
         S_ISSUE: alu_enable = 1'b1;
         S_RESP:  resp_valid[owner_q] = 1'b1;
         default: busy = 1'b1;
      endcase
   end

   assign alu_opA   = alu_opa_q;
   assign alu_opB   = alu_opb_q;
   assign alu_op    = alu_op_q;
   assign resp_data = resp_data_q;
   assign resp_err  = resp_err_q;

endmodule

// File: tb/tb_alu_scheduler.sv
// Directed bench: a behavioural negedge ALU sits behind the scheduler; expected values are hand-computed.
module tb_alu_scheduler;

   logic        clk;
   logic        rst_n;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [63:0] req_opA;
   logic [63:0] req_opB;
   logic [7:0]  req_op;
   logic [1:0]  resp_valid;
   logic [1:0]  resp_ready;
   logic [31:0] resp_data;
   logic        resp_err;
   logic        busy;
   logic        alu_enable;
   logic [31:0] alu_opA;
   logic [31:0] alu_opB;
   logic [3:0]  alu_op;
   logic [31:0] alu_result;

   int checks   = 0;
   int failures = 0;

   alu_scheduler #(.NUM_REQ(2), .DATA_W(32), .OP_W(4), .NUM_OPS(7)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_opA    (req_opA),
      .req_opB    (req_opB),
      .req_op     (req_op),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .resp_err   (resp_err),
      .busy       (busy),
      .alu_enable (alu_enable),
      .alu_opA    (alu_opA),
      .alu_opB    (alu_opB),
      .alu_op     (alu_op),
      .alu_result (alu_result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural ALU: registers its result on the falling edge while enabled.
   always @(negedge clk) begin
      if (alu_enable) begin
         case (alu_op)
            4'd0:    alu_result <= alu_opA + alu_opB;
            4'd1:    alu_result <= alu_opA - alu_opB;
            4'd2:    alu_result <= alu_opA & alu_opB;
            4'd3:    alu_result <= alu_opA | alu_opB;
            4'd4:    alu_result <= alu_opA ^ alu_opB;
            4'd5:    alu_result <= alu_opA << alu_opB[4:0];
            4'd6:    alu_result <= alu_opA >> alu_opB[4:0];
            default: alu_result <= 32'd0;
         endcase
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int r, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
      req_opA[r*32 +: 32] = a;
      req_opB[r*32 +: 32] = b;
      req_op[r*4 +: 4]    = op;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      req_valid = 2'b00;
      step();
      step();
      rst_n = 1'b1;
      #1;
   endtask

   // Starts in IDLE with inputs settled; grant, wait for response, accept it.
   task automatic run_op(input string tag, input logic [1:0] exp_g, input logic [31:0] exp_d,
                         input logic exp_e, input bit hold);
      int cyc = 0;
      int en  = 0;
      check_eq({tag, ".ready"}, 32'(req_ready), 32'(exp_g));
      step();
      if (!hold) req_valid = req_valid & ~exp_g;
      cyc = 1;
      while (resp_valid == 2'b00 && cyc < 6) begin
         if (alu_enable) en++;
         step();
         cyc++;
      end
      check_eq({tag, ".lat"}, 32'(cyc), exp_e ? 32'd1 : 32'd2);
      check_eq({tag, ".rvalid"}, 32'(resp_valid), 32'(exp_g));
      check_eq({tag, ".data"}, resp_data, exp_d);
      check_eq({tag, ".err"}, 32'(resp_err), 32'(exp_e));
      check_eq({tag, ".enpulse"}, 32'(en), exp_e ? 32'd0 : 32'd1);
      step();
      check_eq({tag, ".idle"}, 32'(busy), 32'd0);
   endtask

   initial begin
      req_opA    = '0;
      req_opB    = '0;
      req_op     = '0;
      resp_ready = 2'b11;
      do_reset();

      // Reset state
      check_eq("rst.busy",  32'(busy), 32'd0);
      check_eq("rst.rvld",  32'(resp_valid), 32'd0);
      check_eq("rst.data",  resp_data, 32'd0);
      check_eq("rst.err",   32'(resp_err), 32'd0);
      check_eq("rst.en",    32'(alu_enable), 32'd0);
      check_eq("rst.opA",   alu_opA, 32'd0);
      check_eq("rst.op",    32'(alu_op), 32'd0);

      // 1 single add
      set_req(0, 32'd5, 32'd7, 4'd0);
      req_valid = 2'b01;
      #1;
      run_op("add", 2'b01, 32'd12, 1'b0, 1'b0);
      check_eq("add.opA_hold", alu_opA, 32'd5);
      check_eq("add.opB_hold", alu_opB, 32'd7);

      // 2 contention from reset, alternating grants
      do_reset();
      set_req(0, 32'd1, 32'd1, 4'd0);
      set_req(1, 32'd3, 32'd5, 4'd4);
      req_valid = 2'b11;
      #1;
      run_op("rr0", 2'b01, 32'd2, 1'b0, 1'b1);
      run_op("rr1", 2'b10, 32'd6, 1'b0, 1'b1);
      run_op("rr2", 2'b01, 32'd2, 1'b0, 1'b1);
      run_op("rr3", 2'b10, 32'd6, 1'b0, 1'b1);
      req_valid = 2'b00;
      #1;

      // 3 illegal op on requester 1
      set_req(1, 32'd9, 32'd9, 4'hA);
      req_valid = 2'b10;
      #1;
      run_op("ill", 2'b10, 32'd0, 1'b1, 1'b0);

      // 4 backpressure: owner not ready, non-owner ready ignored, no grant meanwhile
      resp_ready = 2'b10;
      set_req(0, 32'd3, 32'd5, 4'd1);
      req_valid = 2'b01;
      #1;
      check_eq("bp.ready", 32'(req_ready), 32'd1);
      step();
      set_req(1, 32'd2, 32'd2, 4'd0);
      req_valid = 2'b10;
      check_eq("bp.en", 32'(alu_enable), 32'd1);
      step();
      for (int i = 0; i < 4; i++) begin
         check_eq("bp.rvalid", 32'(resp_valid), 32'd1);
         check_eq("bp.data", resp_data, 32'hFFFF_FFFE);
         check_eq("bp.nogrant", 32'(req_ready), 32'd0);
         step();
      end
      resp_ready = 2'b11;
      step();
      run_op("bp.next", 2'b10, 32'd4, 1'b0, 1'b0);

      // 5 reset during ISSUE
      set_req(0, 32'd10, 32'd20, 4'd0);
      req_valid = 2'b01;
      #1;
      step();
      check_eq("mid.issue", 32'(alu_enable), 32'd1);
      req_valid = 2'b00;
      rst_n     = 1'b0;
      step();
      check_eq("mid.busy", 32'(busy), 32'd0);
      check_eq("mid.rvld", 32'(resp_valid), 32'd0);
      check_eq("mid.en",   32'(alu_enable), 32'd0);
      check_eq("mid.opA",  alu_opA, 32'd0);
      check_eq("mid.data", resp_data, 32'd0);
      rst_n = 1'b1;
      step();
      check_eq("mid.still_idle", 32'(resp_valid), 32'd0);
      set_req(0, 32'd1, 32'd2, 4'd3);
      set_req(1, 32'd1, 32'd2, 4'd2);
      req_valid = 2'b11;
      #1;
      run_op("mid.ptr0", 2'b01, 32'd3, 1'b0, 1'b0);
      req_valid = 2'b00;
      #1;

      // 6 shifts
      set_req(0, 32'd1, 32'd31, 4'd5);
      req_valid = 2'b01;
      #1;
      run_op("sll", 2'b01, 32'h8000_0000, 1'b0, 1'b0);
      set_req(1, 32'h8000_0000, 32'd31, 4'd6);
      req_valid = 2'b10;
      #1;
      run_op("srl", 2'b10, 32'd1, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
